// File: rtl/irda_fir_lppm_decoder.sv
// L-PPM chip decoder for the FIR receive path: collects 2**BITS_PER_SYM chips per symbol,
// decodes the one-hot position, serialises the result LSB first and counts bad symbols.
module irda_fir_lppm_decoder #(
    parameter int BITS_PER_SYM = 2,
    parameter int ERR_CNT_W    = 8
) (
    input  logic                    clk,
    input  logic                    wb_rst_i,
    input  logic                    fir_rx_chip_enable,
    input  logic                    ppmd_restart,
    input  logic                    fd_o,
    input  logic                    ppmd_bad_cnt_clr,
    output logic [BITS_PER_SYM-1:0] ppmd_sym_o,
    output logic                    ppmd_sym_valid,
    output logic                    ppmd_bad_chip,
    output logic                    ppmd_o,
    output logic                    ppmd_bit_valid,
    output logic [ERR_CNT_W-1:0]    ppmd_bad_cnt
);

    localparam int CHIPS = 2 ** BITS_PER_SYM;
    localparam logic [BITS_PER_SYM-1:0] LAST_CHIP = BITS_PER_SYM'(CHIPS - 1);
    localparam logic [2:0] SER_BITS = 3'(BITS_PER_SYM - 1);

    logic [BITS_PER_SYM-1:0] chip_idx;
    logic [CHIPS-2:0]        chip_buf;
    logic [CHIPS-1:0]        full_vec;
    logic [BITS_PER_SYM-1:0] hit_idx;
    logic                    hit_seen;
    logic                    hit_multi;
    logic                    dec_good;
    logic [BITS_PER_SYM-1:0] dec_val;
    logic                    completing;
    logic [BITS_PER_SYM-1:0] shift_reg;
    logic [2:0]              bits_left;

    // The last chip is never buffered; it is taken live from fd_o on the completing strobe.
    always_comb begin
        full_vec  = {fd_o, chip_buf};
        hit_seen  = 1'b0;
        hit_multi = 1'b0;
        hit_idx   = '0;
        for (int i = 0; i < CHIPS; i++) begin
            if (full_vec[i]) begin
                if (hit_seen) hit_multi = 1'b1;
                hit_seen = 1'b1;
                hit_idx  = BITS_PER_SYM'(i);
            end
        end
        dec_good = hit_seen & ~hit_multi;
        dec_val  = dec_good ? hit_idx : '0;
    end

    assign completing = fir_rx_chip_enable & ~ppmd_restart & (chip_idx == LAST_CHIP);

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            chip_idx       <= '0;
            chip_buf       <= '0;
            ppmd_sym_o     <= '0;
            ppmd_sym_valid <= 1'b0;
            ppmd_bad_chip  <= 1'b0;
            ppmd_o         <= 1'b0;
            ppmd_bit_valid <= 1'b0;
            shift_reg      <= '0;
            bits_left      <= '0;
        end else begin
            ppmd_sym_valid <= 1'b0;
            ppmd_bad_chip  <= 1'b0;
            ppmd_bit_valid <= 1'b0;
            if (ppmd_restart) begin
                // The chip present during restart is chip 0 of the new symbol.
                chip_idx  <= BITS_PER_SYM'(1);
                chip_buf  <= (CHIPS - 1)'(fd_o);
                ppmd_o    <= 1'b0;
                bits_left <= '0;
                shift_reg <= '0;
            end else if (fir_rx_chip_enable) begin
                if (completing) begin
                    chip_idx       <= '0;
                    ppmd_sym_o     <= dec_val;
                    ppmd_sym_valid <= 1'b1;
                    ppmd_bad_chip  <= ~dec_good;
                    ppmd_o         <= dec_val[0];
                    ppmd_bit_valid <= 1'b1;
                    shift_reg      <= dec_val >> 1;
                    bits_left      <= SER_BITS;
                end else begin
                    chip_idx <= chip_idx + BITS_PER_SYM'(1);
                    for (int i = 0; i < CHIPS - 1; i++) begin
                        if (chip_idx == BITS_PER_SYM'(i)) chip_buf[i] <= fd_o;
                    end
                    if (bits_left != 3'd0) begin
                        ppmd_o         <= shift_reg[0];
                        ppmd_bit_valid <= 1'b1;
                        shift_reg      <= shift_reg >> 1;
                        bits_left      <= bits_left - 3'd1;
                    end
                end
            end
        end
    end

    // Clear takes priority over a bad symbol arriving in the same cycle.
    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ppmd_bad_cnt <= '0;
        end else if (ppmd_bad_cnt_clr) begin
            ppmd_bad_cnt <= '0;
        end else if (completing && !dec_good && !(&ppmd_bad_cnt)) begin
            ppmd_bad_cnt <= ppmd_bad_cnt + ERR_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_irda_fir_lppm_decoder.sv
// Bench for irda_fir_lppm_decoder: four parameterisations share one input stream and are
// compared every cycle against a chip-list reference model plus a few directed checks.
module tb_irda_fir_lppm_decoder;

    logic clk;
    logic rst;
    logic en;
    logic rs;
    logic fd;
    logic clr;

    logic [1:0] sym0, sym1;
    logic [2:0] sym2;
    logic [0:0] sym3;
    logic [7:0] cnt0, cnt2, cnt3;
    logic [1:0] cnt1;
    logic [3:0] sv, bc, so, bv;

    int total = 0;
    int bad = 0;

    int bitsOf[4] = '{2, 2, 3, 1};
    int errwOf[4] = '{8, 2, 8, 8};

    int mPos[4];
    int mChips[4][16];
    int mSym[4];
    int mSv[4];
    int mBc[4];
    int mO[4];
    int mBv[4];
    int mCnt[4];
    int mVal[4];
    int mLeft[4];

    irda_fir_lppm_decoder #(.BITS_PER_SYM(2), .ERR_CNT_W(8)) dut0 (
        .clk(clk), .wb_rst_i(rst), .fir_rx_chip_enable(en), .ppmd_restart(rs), .fd_o(fd),
        .ppmd_bad_cnt_clr(clr), .ppmd_sym_o(sym0), .ppmd_sym_valid(sv[0]), .ppmd_bad_chip(bc[0]),
        .ppmd_o(so[0]), .ppmd_bit_valid(bv[0]), .ppmd_bad_cnt(cnt0));

    irda_fir_lppm_decoder #(.BITS_PER_SYM(2), .ERR_CNT_W(2)) dut1 (
        .clk(clk), .wb_rst_i(rst), .fir_rx_chip_enable(en), .ppmd_restart(rs), .fd_o(fd),
        .ppmd_bad_cnt_clr(clr), .ppmd_sym_o(sym1), .ppmd_sym_valid(sv[1]), .ppmd_bad_chip(bc[1]),
        .ppmd_o(so[1]), .ppmd_bit_valid(bv[1]), .ppmd_bad_cnt(cnt1));

    irda_fir_lppm_decoder #(.BITS_PER_SYM(3), .ERR_CNT_W(8)) dut2 (
        .clk(clk), .wb_rst_i(rst), .fir_rx_chip_enable(en), .ppmd_restart(rs), .fd_o(fd),
        .ppmd_bad_cnt_clr(clr), .ppmd_sym_o(sym2), .ppmd_sym_valid(sv[2]), .ppmd_bad_chip(bc[2]),
        .ppmd_o(so[2]), .ppmd_bit_valid(bv[2]), .ppmd_bad_cnt(cnt2));

    irda_fir_lppm_decoder #(.BITS_PER_SYM(1), .ERR_CNT_W(8)) dut3 (
        .clk(clk), .wb_rst_i(rst), .fir_rx_chip_enable(en), .ppmd_restart(rs), .fd_o(fd),
        .ppmd_bad_cnt_clr(clr), .ppmd_sym_o(sym3), .ppmd_sym_valid(sv[3]), .ppmd_bad_chip(bc[3]),
        .ppmd_o(so[3]), .ppmd_bit_valid(bv[3]), .ppmd_bad_cnt(cnt3));

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: symbol = position of the single high chip among the L chips seen since
    // the symbol boundary; its bits then leave LSB first, one per chip strobe.
    task automatic modelStep(input logic e, input logic r, input logic f, input logic c);
        for (int d = 0; d < 4; d++) begin
            int l;
            int maxCnt;
            int ones;
            int idx;
            int isBad;
            l      = 1 << bitsOf[d];
            maxCnt = (1 << errwOf[d]) - 1;
            isBad  = 0;
            mSv[d] = 0;
            mBc[d] = 0;
            mBv[d] = 0;
            if (r) begin
                mPos[d] = 1;
                mChips[d][0] = int'(f);
                for (int i = 1; i < l; i++) mChips[d][i] = 0;
                mLeft[d] = 0;
                mO[d] = 0;
            end else if (e) begin
                if (mPos[d] == l - 1) begin
                    ones = 0;
                    idx  = 0;
                    for (int i = 0; i < l - 1; i++) begin
                        if (mChips[d][i] != 0) begin
                            ones++;
                            idx = i;
                        end
                    end
                    if (f) begin
                        ones++;
                        idx = l - 1;
                    end
                    if (ones == 1) mVal[d] = idx;
                    else begin
                        mVal[d] = 0;
                        isBad = 1;
                    end
                    mSym[d]  = mVal[d];
                    mSv[d]   = 1;
                    mBc[d]   = isBad;
                    mO[d]    = mVal[d] % 2;
                    mBv[d]   = 1;
                    mLeft[d] = bitsOf[d] - 1;
                    mPos[d]  = 0;
                end else begin
                    mChips[d][mPos[d]] = int'(f);
                    mPos[d]++;
                    if (mLeft[d] > 0) begin
                        mO[d]  = (mVal[d] >> (bitsOf[d] - mLeft[d])) % 2;
                        mBv[d] = 1;
                        mLeft[d]--;
                    end
                end
            end
            if (c) mCnt[d] = 0;
            else if (isBad != 0 && mCnt[d] < maxCnt) mCnt[d]++;
        end
    endtask

    task automatic checkDut(input int d, input logic [31:0] sym, input logic [31:0] cnt);
        checkVal($sformatf("d%0d_sym", d), sym, 32'(mSym[d]));
        checkVal($sformatf("d%0d_sym_valid", d), 32'(sv[d]), 32'(mSv[d]));
        checkVal($sformatf("d%0d_bad_chip", d), 32'(bc[d]), 32'(mBc[d]));
        checkVal($sformatf("d%0d_ser_bit", d), 32'(so[d]), 32'(mO[d]));
        checkVal($sformatf("d%0d_bit_valid", d), 32'(bv[d]), 32'(mBv[d]));
        checkVal($sformatf("d%0d_bad_cnt", d), cnt, 32'(mCnt[d]));
    endtask

    task automatic checkOutput();
        checkDut(0, 32'(sym0), 32'(cnt0));
        checkDut(1, 32'(sym1), 32'(cnt1));
        checkDut(2, 32'(sym2), 32'(cnt2));
        checkDut(3, 32'(sym3), 32'(cnt3));
    endtask

    // Inputs change just after the falling edge; outputs are sampled on the next falling edge.
    task automatic applyStimulus(input logic e, input logic r, input logic f, input logic c);
        en  = e;
        rs  = r;
        fd  = f;
        clr = c;
        @(posedge clk);
        modelStep(e, r, f, c);
        @(negedge clk);
        checkOutput();
    endtask

    task automatic sendSym(input logic [15:0] pat, input int n, input logic clrLast);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, pat[i], clrLast && (i == n - 1));
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        en  = 1'b0;
        rs  = 1'b0;
        fd  = 1'b0;
        clr = 1'b0;
        for (int d = 0; d < 4; d++) begin
            mPos[d] = 0; mSym[d] = 0; mSv[d] = 0; mBc[d] = 0; mO[d] = 0;
            mBv[d] = 0; mCnt[d] = 0; mVal[d] = 0; mLeft[d] = 0;
            for (int i = 0; i < 16; i++) mChips[d][i] = 0;
        end
        repeat (2) @(negedge clk);
        checkOutput();
        rst = 1'b0;
        $display("[TB] reset released");

        // Restart carrying a high chip 0, then three low chips: symbol 0.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        sendSym(16'h0, 3, 1'b0);
        checkVal("dir_4ppm_sym0_valid", 32'(sv[0]), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkVal("dir_4ppm_bit1_valid", 32'(bv[0]), 32'd1);

        // Symbols 1, 2, 3 back to back.
        sendSym(16'h2, 3, 1'b0);
        sendSym(16'h4, 4, 1'b0);
        checkVal("dir_4ppm_sym2", 32'(sym0), 32'd2);
        sendSym(16'h8, 4, 1'b0);
        checkVal("dir_4ppm_sym3", 32'(sym0), 32'd3);

        // Two bad symbols, then a third together with a counter clear.
        sendSym(16'h3, 4, 1'b0);
        sendSym(16'h0, 4, 1'b0);
        checkVal("dir_bad_cnt_two", 32'(cnt0), 32'd2);
        sendSym(16'hF, 4, 1'b1);
        checkVal("dir_clr_wins", 32'(cnt0), 32'd0);

        // Partial symbol then resync; afterwards abort the serialiser mid-symbol.
        sendSym(16'h2, 2, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        sendSym(16'h2, 3, 1'b0);
        checkVal("dir_resync_sym2", 32'(sym0), 32'd2);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkVal("dir_abort_bit_valid", 32'(bv[0]), 32'd0);
        checkVal("dir_abort_bit", 32'(so[0]), 32'd0);

        // Five bad symbols saturate the 2-bit counter.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        sendSym(16'h0, 3, 1'b0);
        for (int k = 0; k < 4; k++) sendSym(16'h0, 4, 1'b0);
        checkVal("dir_sat_cnt", 32'(cnt1), 32'd3);

        // 8PPM: chip 5 high -> symbol 5.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        sendSym(16'h10, 7, 1'b0);
        checkVal("dir_8ppm_sym5", 32'(sym2), 32'd5);

        // 2PPM: "01" is symbol 1, "11" is bad.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        checkVal("dir_2ppm_sym1", 32'(sym3), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        checkVal("dir_2ppm_bad", 32'(bc[3]), 32'd1);

        // Random chips, gaps, resyncs and clears.
        for (int k = 0; k < 600; k++) begin
            applyStimulus(($urandom % 4) != 0, ($urandom % 40) == 0,
                          ($urandom % 4) == 0, ($urandom % 60) == 0);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/irda_fir_lppm_decoder.md
Name: irda_fir_lppm_decoder

Overview:
Parametrised L-PPM chip decoder for the FIR receive path. It generalises the fixed 4PPM decoder to L = 2^BITS_PER_SYM chips per symbol. It decodes each symbol to BITS_PER_SYM data bits and delivers them both in parallel and as an LSB-first serial stream with explicit valid strobes. It also tracks bad symbols with a saturating error counter. It sits between the FIR chip sampler (fd_o) and the FIR deframer/CRC logic.

Parameters:
BITS_PER_SYM, 2, data bits per symbol (legal 1..4); CHIPS = 2**BITS_PER_SYM is a derived localparam; default 2 gives 4PPM.
ERR_CNT_W, 8, width of the bad-symbol counter.

Ports:
clk  input  1  system clock
wb_rst_i  input  1  asynchronous active-high reset
fir_rx_chip_enable  input  1  one-cycle strobe per received chip
ppmd_restart  input  1  symbol resync; the current fd_o is chip 0
fd_o  input  1  current chip value
ppmd_bad_cnt_clr  input  1  synchronous clear of the error counter
ppmd_sym_o  output  BITS_PER_SYM  last decoded symbol
ppmd_sym_valid  output  1  one-cycle pulse: new symbol on ppmd_sym_o
ppmd_bad_chip  output  1  one-cycle pulse, coincident with ppmd_sym_valid, when the symbol is not one-hot
ppmd_o  output  1  serial data bit, LSB first
ppmd_bit_valid  output  1  one-cycle pulse: new bit on ppmd_o
ppmd_bad_cnt  output  ERR_CNT_W  saturating bad-symbol count

Behaviour:
- Clock and reset: single clock clk. Reset wb_rst_i is asynchronous and active-high. Every register and every output resets to 0.
- Chip counter chip_idx (width BITS_PER_SYM):
  - ppmd_restart sets it to 1.
  - Otherwise, fir_rx_chip_enable increments it, wrapping at CHIPS-1 -> 0.
  - ppmd_restart has priority over fir_rx_chip_enable.
- Chip buffer (CHIPS-1 bits):
  - On enable with chip_idx = k < CHIPS-1, store fd_o at position k.
  - On ppmd_restart, store fd_o at position 0 and clear positions 1..CHIPS-2.
- Symbol completion: enable with chip_idx = CHIPS-1.
  - Full vector = buffer plus the current fd_o as the last chip.
  - If exactly one chip is 1: symbol value = index of that chip (chip 0 -> 0, last chip -> CHIPS-1) and the symbol is good.
  - Otherwise (all zero or multiple ones): value = 0 and the symbol is bad.
- Latency: on the clk edge of the completing enable, load ppmd_sym_o and pulse ppmd_sym_valid for 1 cycle. ppmd_bad_chip pulses in the same cycle if the symbol is bad. ppmd_sym_o holds until the next symbol.
- Serialiser:
  - On symbol completion, ppmd_o <= value[0] and ppmd_bit_valid pulses, in the same cycle as ppmd_sym_valid.
  - The remaining bits value[1..BITS_PER_SYM-1] shift out one per subsequent fir_rx_chip_enable, each with a ppmd_bit_valid pulse.
  - Because BITS_PER_SYM <= CHIPS-1 for legal values, the serialiser is always idle before the next completion.
  - ppmd_o holds its value between strobes.
  - A bad symbol still emits BITS_PER_SYM zero bits.
- ppmd_restart:
  - Aborts the serialiser: remaining bits are dropped, ppmd_o <= 0, no ppmd_bit_valid.
  - Suppresses any completion in that cycle.
  - Does not modify ppmd_sym_o or ppmd_bad_cnt.
- Error counter:
  - Increments by 1 on each bad symbol and saturates at all-ones.
  - ppmd_bad_cnt_clr sets it to 0. Clear wins over a simultaneous increment.
- No enable: with fir_rx_chip_enable low and no restart, all state holds and all pulses are 0.
- Back-to-back enables on consecutive clocks are legal. Chip rate is limited only by clk.

Test Plan:
1. Default params. Reset, then restart with fd_o=1, then enables with fd_o=0,0,0 -> ppmd_sym_o=0, sym_valid 1 cycle, bits 0,0 with 2 bit_valid pulses, bad_chip=0.
2. Default params. Symbols 0100, 0010, 0001 sent back-to-back at 1 enable/cycle -> sym 1,2,3; serial stream 1,0, 0,1, 1,1; no bad_chip; bad_cnt=0.
3. Default params. Symbols 1100 then 0000 -> sym 0 both times, bad_chip pulses twice, bad_cnt=2. Then assert clr concurrently with a third bad symbol -> bad_cnt=0.
4. Default params. After 2 chips of a symbol, assert ppmd_restart with fd_o=0, then chips 0,1,0 -> decodes 2. The partial symbol produces no sym_valid. Also assert restart between serial bits -> no further bit_valid, ppmd_o=0.
5. ERR_CNT_W=2. Five bad symbols -> count 1,2,3,3,3.
6. BITS_PER_SYM=3 (8PPM) and BITS_PER_SYM=1 (2PPM). Chip 5 high in 8 chips -> sym 5, bits 1,0,1. 2PPM "01" -> sym 1, one bit 1; "11" -> bad_chip.
